// File: rtl/interlock_pkg.sv
// Shared constants for the airlock interlock: clock rate, input conditioning
// defaults, and the pushbutton index map used by the interlock FSM.
package interlock_pkg;

  localparam int CLK_HZ = 50_000_000;

  // 5 ms debounce, 0.5 s until first auto-repeat, then 10 repeats per second.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250_000;
  localparam int DEFAULT_REPEAT_DELAY    = 25_000_000;
  localparam int DEFAULT_REPEAT_PERIOD   = 5_000_000;

  localparam int KEY_RESET_IDX  = 0;
  localparam int KEY_ARRIVE_IDX = 1;
  localparam int KEY_DEPART_IDX = 2;

endpackage

// File: rtl/interlock_input_conditioner_debounce_bit.sv
// One input bit: 2-flop synchronizer, debounce counter, stable level and
// registered rise/fall pulses. INVERT=1 turns an active-low input active-high.
module debounce_bit
  import interlock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level,
  output logic level_nxt,
  output logic rise,
  output logic fall
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          synced;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Sync flops reset to the released level so no edge is seen at reset exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= INVERT;
      sync2_q <= INVERT;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    synced   = INVERT ? ~sync2_q : sync2_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = synced;
      cnt_d    = '0;
      rise_d   = synced;
      fall_d   = ~synced;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level     = stable_q;
  assign level_nxt = stable_d;
  assign rise      = rise_q;
  assign fall      = fall_q;

endmodule

// File: rtl/interlock_input_conditioner.sv
// Synchronizes and debounces raw KEY/SW board inputs for the interlock FSM.
// Optional build macro INPUT_REPEAT_EN adds per-key auto-repeat press pulses.
module interlock_input_conditioner
  import interlock_pkg::*;
#(
  parameter int N_KEY           = 4,
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic [N_KEY-1:0] KEY,
  input  logic [N_SW-1:0]  SW,
  output logic [N_KEY-1:0] key_level,
  output logic [N_KEY-1:0] key_press,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_SW-1:0]  sw_change
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("interlock_input_conditioner: cycle parameters must be >= 1");
  end

  logic [N_KEY-1:0] key_level_nxt;
  logic [N_KEY-1:0] key_rise;
  logic [N_KEY-1:0] key_fall;
  logic [N_SW-1:0]  sw_level_nxt;
  logic [N_SW-1:0]  sw_rise;
  logic [N_SW-1:0]  sw_fall;

  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (1'b1)
    ) u_db (
      .clk      (CLOCK_50),
      .rst_n    (Reset),
      .raw_in   (KEY[i]),
      .level    (key_level[i]),
      .level_nxt(key_level_nxt[i]),
      .rise     (key_rise[i]),
      .fall     (key_fall[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (1'b0)
    ) u_db (
      .clk      (CLOCK_50),
      .rst_n    (Reset),
      .raw_in   (SW[i]),
      .level    (sw_level[i]),
      .level_nxt(sw_level_nxt[i]),
      .rise     (sw_rise[i]),
      .fall     (sw_fall[i])
    );
  end

  assign sw_change = sw_rise | sw_fall;

  logic unused_pulses;
  assign unused_pulses = ^{key_fall, sw_level_nxt};

`ifdef INPUT_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic [N_KEY-1:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [N_KEY-1:0]         rpt_started_q, rpt_started_d;
  logic [N_KEY-1:0]         rpt_pulse_q, rpt_pulse_d;
  logic [N_KEY-1:0][RW-1:0] rpt_limit;

  // Counter measures cycles since the last press pulse; it is cleared on the
  // very edge the debounced level drops so a due repeat is never issued.
  always_comb begin
    rpt_cnt_d     = rpt_cnt_q;
    rpt_started_d = rpt_started_q;
    rpt_pulse_d   = '0;
    rpt_limit     = '0;
    for (int i = 0; i < N_KEY; i++) begin
      rpt_limit[i] = rpt_started_q[i] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
      if (!key_level_nxt[i] || !key_level[i]) begin
        rpt_cnt_d[i]     = '0;
        rpt_started_d[i] = 1'b0;
      end else if (rpt_cnt_q[i] + RW'(1) == rpt_limit[i]) begin
        rpt_cnt_d[i]     = '0;
        rpt_started_d[i] = 1'b1;
        rpt_pulse_d[i]   = 1'b1;
      end else begin
        rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      rpt_cnt_q     <= '0;
      rpt_started_q <= '0;
      rpt_pulse_q   <= '0;
    end else begin
      rpt_cnt_q     <= rpt_cnt_d;
      rpt_started_q <= rpt_started_d;
      rpt_pulse_q   <= rpt_pulse_d;
    end
  end

  assign key_press = key_rise | rpt_pulse_q;
`else
  logic unused_key_nxt;
  assign unused_key_nxt = ^key_level_nxt;
  assign key_press      = key_rise;
`endif

endmodule

// File: tb/tb_interlock_input_conditioner.sv
// Directed bench for interlock_input_conditioner with short debounce/repeat
// timings; expectations follow the INPUT_REPEAT_EN build setting.
module tb_interlock_input_conditioner;

  localparam int N_KEY = 4;
  localparam int N_SW  = 10;

  logic             clk;
  logic             rst_n;
  logic [N_KEY-1:0] key;
  logic [N_SW-1:0]  sw;
  logic [N_KEY-1:0] key_level;
  logic [N_KEY-1:0] key_press;
  logic [N_SW-1:0]  sw_level;
  logic [N_SW-1:0]  sw_change;

  int vectors;
  int miscompares;

  interlock_input_conditioner #(
    .N_KEY          (N_KEY),
    .N_SW           (N_SW),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .CLOCK_50 (clk),
    .Reset    (rst_n),
    .KEY      (key),
    .SW       (sw),
    .key_level(key_level),
    .key_press(key_press),
    .sw_level (sw_level),
    .sw_change(sw_change)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Repeat pulses at +10, +13, ... after acceptance; key released after +25
  // drops the level at +31, which suppresses the repeat due on that edge.
  function automatic logic rpt_exp(input int k);
`ifdef INPUT_REPEAT_EN
    return (k >= 10) && (((k - 10) % 3) == 0) && (k < 31);
`else
    return (k < 0);
`endif
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    key   = 4'hF;
    sw    = '0;
    rst_n = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({key_level, key_press, sw_level, sw_change}), 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      check("idle_after_reset", 32'({key_level, key_press, sw_level, sw_change}), 32'h0);
    end

    // KEY[0] press, accepted 6 cycles later, release without pulse
    key[0] = 1'b0;
    repeat (5) step();
    check("k0_level_early", 32'(key_level), 32'h0);
    step();
    check("k0_level_accept", 32'(key_level), 32'h1);
    check("k0_press_pulse", 32'(key_press), 32'h1);
    step();
    check("k0_press_width", 32'(key_press), 32'h0);
    check("k0_level_held", 32'(key_level), 32'h1);
    key[0] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      check("k0_release_wait_level", 32'(key_level), 32'h1);
      check("k0_release_wait_press", 32'(key_press), 32'h0);
    end
    step();
    check("k0_release_level", 32'(key_level), 32'h0);
    check("k0_release_no_press", 32'(key_press), 32'h0);

    // SW[3] glitch of 3 cycles is rejected
    sw[3] = 1'b1;
    repeat (3) step();
    sw[3] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      check("sw3_glitch", 32'({sw_level, sw_change}), 32'h0);
    end

    // SW[3] held high, then low: one change pulse each way
    sw[3] = 1'b1;
    repeat (5) step();
    check("sw3_rise_early", 32'({sw_level, sw_change}), 32'h0);
    step();
    check("sw3_rise_level", 32'(sw_level), 32'h008);
    check("sw3_rise_change", 32'(sw_change), 32'h008);
    step();
    check("sw3_rise_width", 32'(sw_change), 32'h0);
    sw[3] = 1'b0;
    repeat (5) step();
    check("sw3_fall_early_level", 32'(sw_level), 32'h008);
    check("sw3_fall_early_change", 32'(sw_change), 32'h0);
    step();
    check("sw3_fall_level", 32'(sw_level), 32'h0);
    check("sw3_fall_change", 32'(sw_change), 32'h008);
    step();
    check("sw3_fall_width", 32'(sw_change), 32'h0);

    // KEY[1] and SW[9] change on the same edge
    key[1] = 1'b0;
    sw[9]  = 1'b1;
    repeat (6) step();
    check("simul_key_press", 32'(key_press), 32'h2);
    check("simul_sw_change", 32'(sw_change), 32'h200);
    check("simul_levels", 32'({key_level, sw_level}), 32'({4'h2, 10'h200}));
    step();
    check("simul_pulses_clear", 32'({key_press, sw_change}), 32'h0);
    key[1] = 1'b1;
    sw[9]  = 1'b0;
    repeat (6) step();
    check("simul_release_press", 32'(key_press), 32'h0);
    check("simul_release_change", 32'(sw_change), 32'h200);
    check("simul_release_levels", 32'({key_level, sw_level}), 32'h0);
    repeat (2) step();

    // SW[5] on during reset is learned after release
    sw    = 10'h020;
    rst_n = 1'b0;
    #1;
    check("sw5_in_reset", 32'({key_level, key_press, sw_level, sw_change}), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      check("sw5_wait_change", 32'(sw_change), 32'h0);
    end
    step();
    check("sw5_init_change", 32'(sw_change), 32'h020);
    check("sw5_init_level", 32'(sw_level), 32'h020);
    step();
    check("sw5_init_width", 32'(sw_change), 32'h0);

    // Reset mid-debounce of KEY[2] discards the partial count
    key[2] = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #2;
    check("mid_reset_levels", 32'({key_level, sw_level}), 32'h0);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      check("k2_after_reset_press", 32'(key_press), 32'h0);
      check("k2_after_reset_level", 32'(key_level), 32'h0);
      check("k2_after_reset_change", 32'(sw_change), 32'h0);
    end
    step();
    check("k2_reaccept_press", 32'(key_press), 32'h4);
    check("k2_reaccept_change", 32'(sw_change), 32'h020);
    key[2] = 1'b1;
    sw     = '0;
    repeat (8) step();
    check("quiet_before_repeat", 32'({key_level, sw_level}), 32'h0);

    // Auto-repeat while KEY[0] stays held
    key[0] = 1'b0;
    repeat (5) step();
    check("rpt_before_accept", 32'(key_press), 32'h0);
    step();
    check("rpt_initial_press", 32'(key_press), 32'h1);
    for (int k = 1; k <= 33; k++) begin
      step();
      check("rpt_press_k", 32'(key_press[0]), 32'(rpt_exp(k)));
      if (k == 30) check("rpt_level_still_held", 32'(key_level[0]), 32'h1);
      if (k == 31) check("rpt_level_released", 32'(key_level[0]), 32'h0);
      if (k == 25) key[0] = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
